// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcodes, ALU operation codes,
// load-width codes, special register indices and the decoded control bundle.
package mips_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // Operation requested from the EX-stage ALU
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  // Width and signedness of a memory load
  typedef enum logic [1:0] {
    LM_WORD   = 2'b00,
    LM_HALF_S = 2'b01,
    LM_HALF_U = 2'b10,
    LM_BYTE_S = 2'b11
  } load_mode_e;

  // Register indices with fixed read behaviour
  localparam logic [4:0] ZERO      = 5'd0;
  localparam logic [4:0] INPUT_REG = 5'd27;

  // Control bundle carried through the ID/EX register
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    alu_op_e    alu_op;
    load_mode_e load_mode;
  } ctrl_t;

  // All-zero control word: an instruction that does nothing (bubble)
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_decode_stage_if.sv
// Signal bundle between the ID stage and its neighbours: IF/ID inputs,
// the WB write port, the external input word and the ID/EX outputs.
// master = the environment driving the stage, slave = the decode stage.
interface mips_decode_stage_if;
  // IF/ID side
  logic [31:0] instruction;
  logic [31:0] in_new_pc_value;
  // WB write port
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        in_RegWrite;
  // External input word, visible as register 27
  logic [31:0] register_input;
  // ID/EX side
  logic [4:0]  instr_bits_15_11;
  logic [4:0]  instr_bits_20_16;
  logic [31:0] extended_bits;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] new_pc_value;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        Branch;
  logic [1:0]  load_mode;
  logic [2:0]  ALUOp;

  modport master (
    output instruction, in_new_pc_value, write_register, write_data,
           in_RegWrite, register_input,
    input  instr_bits_15_11, instr_bits_20_16, extended_bits, read_data1,
           read_data2, new_pc_value, RegDst, RegWrite, ALUSrc, MemWrite,
           MemRead, MemToReg, Branch, load_mode, ALUOp
  );

  modport slave (
    input  instruction, in_new_pc_value, write_register, write_data,
           in_RegWrite, register_input,
    output instr_bits_15_11, instr_bits_20_16, extended_bits, read_data1,
           read_data2, new_pc_value, RegDst, RegWrite, ALUSrc, MemWrite,
           MemRead, MemToReg, Branch, load_mode, ALUOp
  );
endinterface

// File: rtl/id_regfile.sv
// 32x32 register file for the ID stage: two combinational read ports and
// one write port from WB. r0 reads 0 and r27 reads the external input word;
// writes to either are dropped. Optional macro ID_WB_BYPASS_EN forwards
// same-cycle WB data to the read ports.
module id_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] reg_input_i
);

  logic [31:0] mem_q [32];

  // Read mux shared by both ports; special indices take priority over storage
  // and over the bypass.
  function automatic logic [31:0] read_port(input logic [4:0] idx);
    if (idx == ZERO) begin
      return '0;
    end else if (idx == INPUT_REG) begin
      return reg_input_i;
    end
`ifdef ID_WB_BYPASS_EN
    else if (we_i && (wr_addr_i == idx)) begin
      return wr_data_i;
    end
`endif
    else begin
      return mem_q[idx];
    end
  endfunction

  // Storage update: cleared on reset, otherwise written from WB
  always_ff @(posedge clk) begin
    // NOTE: this array is explicitly cleared on reset because software may
    // read any register before writing it; that forces flops instead of a
    // RAM macro, which is acceptable for 32 entries.
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wr_addr_i != ZERO) && (wr_addr_i != INPUT_REG)) begin
      // NOTE: non-blocking so every reader on this edge sees the pre-edge
      // value; a blocking write would leak the new value into same-edge logic.
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read ports
  always_comb begin
    rs_data_o = read_port(rs_addr_i);
    rt_data_o = read_port(rt_addr_i);
  end

endmodule

// File: rtl/mips_decode_stage.sv
// MIPS instruction-decode stage: opcode decode, register read, immediate
// sign extension and the ID/EX pipeline register (1-cycle latency).
// Optional macro ID_WB_BYPASS_EN: same-cycle WB-to-read forwarding inside
// id_regfile; when undefined a write becomes visible the following cycle.
module mips_decode_stage
  import mips_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  mips_decode_stage_if.slave   bus
);

  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  ctrl_t       ctrl_d;
  logic [31:0] ext_d;

  ctrl_t       ctrl_q;
  logic [4:0]  rd_q;
  logic [4:0]  rt_q;
  logic [31:0] ext_q;
  logic [31:0] rd1_q;
  logic [31:0] rd2_q;
  logic [31:0] pc_q;

  assign opcode = bus.instruction[31:26];
  assign rs_idx = bus.instruction[25:21];
  assign rt_idx = bus.instruction[20:16];

  id_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr_i   (rs_idx),
    .rt_addr_i   (rt_idx),
    .rs_data_o   (rs_val),
    .rt_data_o   (rt_val),
    .we_i        (bus.in_RegWrite),
    .wr_addr_i   (bus.write_register),
    .wr_data_i   (bus.write_data),
    .reg_input_i (bus.register_input)
  );

  // Control decode from the opcode; unknown opcodes become a bubble
  always_comb begin
    // NOTE: default the whole bundle first so every path assigns every field
    // and no latch is inferred for opcodes that leave a field untouched.
    ctrl_d = CTRL_BUBBLE;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      OP_LW, OP_LH, OP_LHU, OP_LB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_op     = ALU_ADD;
        ctrl_d.load_mode  = (opcode == OP_LH)  ? LM_HALF_S :
                            (opcode == OP_LHU) ? LM_HALF_U :
                            (opcode == OP_LB)  ? LM_BYTE_S : LM_WORD;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                           (opcode == OP_ORI)  ? ALU_OR  :
                           (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      default: ctrl_d = CTRL_BUBBLE;
    endcase
  end

  // Immediate is always sign-extended, logical immediates included
  assign ext_d = {{16{bus.instruction[15]}}, bus.instruction[15:0]};

  // ID/EX pipeline register, captured every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_BUBBLE;
      rd_q   <= '0;
      rt_q   <= '0;
      ext_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      pc_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= bus.instruction[15:11];
      rt_q   <= rt_idx;
      ext_q  <= ext_d;
      rd1_q  <= rs_val;
      rd2_q  <= rt_val;
      pc_q   <= bus.in_new_pc_value;
    end
  end

  assign bus.instr_bits_15_11 = rd_q;
  assign bus.instr_bits_20_16 = rt_q;
  assign bus.extended_bits    = ext_q;
  assign bus.read_data1       = rd1_q;
  assign bus.read_data2       = rd2_q;
  assign bus.new_pc_value     = pc_q;
  assign bus.RegDst           = ctrl_q.reg_dst;
  assign bus.RegWrite         = ctrl_q.reg_write;
  assign bus.ALUSrc           = ctrl_q.alu_src;
  assign bus.MemWrite         = ctrl_q.mem_write;
  assign bus.MemRead          = ctrl_q.mem_read;
  assign bus.MemToReg         = ctrl_q.mem_to_reg;
  assign bus.Branch           = ctrl_q.branch;
  assign bus.ALUOp            = ctrl_q.alu_op;
  assign bus.load_mode        = ctrl_q.load_mode;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed self-checking bench for mips_decode_stage. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
module tb_mips_decode_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_decode_stage_if bus ();

  mips_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch,ALUOp,load_mode}
  function automatic logic [11:0] ctrl_obs();
    return {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.MemRead,
            bus.MemToReg, bus.Branch, bus.ALUOp, bus.load_mode};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  // Apply inputs on the falling edge, then wait for the next capture edge
  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    bus.instruction     = instr;
    bus.in_new_pc_value = pc;
    bus.in_RegWrite     = we;
    bus.write_register  = wr;
    bus.write_data      = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {20'd0, ctrl_obs()}, 32'd0);
    check({tag, "_rd1"}, bus.read_data1, 32'd0);
    check({tag, "_rd2"}, bus.read_data2, 32'd0);
    check({tag, "_ext"}, bus.extended_bits, 32'd0);
    check({tag, "_pc"}, bus.new_pc_value, 32'd0);
    check({tag, "_rt"}, {27'd0, bus.instr_bits_20_16}, 32'd0);
    check({tag, "_rd"}, {27'd0, bus.instr_bits_15_11}, 32'd0);
  endtask

  // Opcode table with hand-derived control words
  logic [5:0]  op_tab  [12];
  logic [11:0] exp_tab [12];

  initial begin
    checks = 0;
    errors = 0;
    op_tab[0]  = 6'b000000; exp_tab[0]  = 12'b1100000_010_00; // R-type
    op_tab[1]  = 6'b100011; exp_tab[1]  = 12'b0110110_000_00; // lw
    op_tab[2]  = 6'b100001; exp_tab[2]  = 12'b0110110_000_01; // lh
    op_tab[3]  = 6'b100101; exp_tab[3]  = 12'b0110110_000_10; // lhu
    op_tab[4]  = 6'b100000; exp_tab[4]  = 12'b0110110_000_11; // lb
    op_tab[5]  = 6'b101011; exp_tab[5]  = 12'b0011000_000_00; // sw
    op_tab[6]  = 6'b000100; exp_tab[6]  = 12'b0000001_001_00; // beq
    op_tab[7]  = 6'b001000; exp_tab[7]  = 12'b0110000_000_00; // addi
    op_tab[8]  = 6'b001100; exp_tab[8]  = 12'b0110000_011_00; // andi
    op_tab[9]  = 6'b001101; exp_tab[9]  = 12'b0110000_100_00; // ori
    op_tab[10] = 6'b001010; exp_tab[10] = 12'b0110000_101_00; // slti
    op_tab[11] = 6'b000010; exp_tab[11] = 12'b0000000_000_00; // j: unsupported

    bus.register_input = 32'h0000ABCD;

    // Reset for two cycles with a write pending: it must be ignored
    rst_n = 1'b0;
    step(rtype(5'd5, 5'd6, 5'd7), 32'h0000_0040, 1'b1, 5'd5, 32'hAAAA_5555);
    step(rtype(5'd5, 5'd6, 5'd7), 32'h0000_0044, 1'b1, 5'd5, 32'hAAAA_5555);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Every register reads 0 after reset, except r27
    for (int i = 0; i < 32; i++) begin
      step(rtype(i[4:0], i[4:0], 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
      check($sformatf("rst_read_rs%0d", i), bus.read_data1, (i == 27) ? 32'h0000ABCD : 32'd0);
      check($sformatf("rst_read_rt%0d", i), bus.read_data2, (i == 27) ? 32'h0000ABCD : 32'd0);
    end

    // Write r5, then decode an R-type reading it
    step({6'b111111, 26'd0}, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(rtype(5'd5, 5'd0, 5'd3), 32'h0000_1000, 1'b0, 5'd0, 32'd0);
    check("rtype_rd1", bus.read_data1, 32'hDEADBEEF);
    check("rtype_rd2", bus.read_data2, 32'd0);
    check("rtype_ctrl", {20'd0, ctrl_obs()}, {20'd0, 12'b1100000_010_00});
    check("rtype_rd", {27'd0, bus.instr_bits_15_11}, 32'd3);
    check("rtype_pc", bus.new_pc_value, 32'h0000_1000);

    // lw r8,-4(r1)
    step(32'h8C28FFFC, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
    check("lw_ctrl", {20'd0, ctrl_obs()}, {20'd0, 12'b0110110_000_00});
    check("lw_ext", bus.extended_bits, 32'hFFFFFFFC);
    check("lw_rt", {27'd0, bus.instr_bits_20_16}, 32'd8);
    check("lw_rd1", bus.read_data1, 32'd0);
    check("lw_pc", bus.new_pc_value, 32'h0000_0100);

    // Opcode sweep; negative immediate checks sign extension on every opcode
    for (int k = 0; k < 12; k++) begin
      step({op_tab[k], 5'd5, 5'd6, 16'h8001}, 32'h0000_2000 + k, 1'b0, 5'd0, 32'd0);
      check($sformatf("op%02h_ctrl", op_tab[k]), {20'd0, ctrl_obs()}, {20'd0, exp_tab[k]});
      check($sformatf("op%02h_ext", op_tab[k]), bus.extended_bits, 32'hFFFF8001);
    end

    // Positive immediate stays zero-extended in the upper half
    step({6'b001101, 5'd0, 5'd1, 16'h7FFF}, 32'd0, 1'b0, 5'd0, 32'd0);
    check("ori_ext_pos", bus.extended_bits, 32'h00007FFF);

    // Same-cycle write and read of r9
    step(rtype(5'd9, 5'd9, 5'd0), 32'd0, 1'b1, 5'd9, 32'h12345678);
`ifdef ID_WB_BYPASS_EN
    check("raw_same_rd1", bus.read_data1, 32'h12345678);
    check("raw_same_rd2", bus.read_data2, 32'h12345678);
`else
    check("raw_same_rd1", bus.read_data1, 32'd0);
    check("raw_same_rd2", bus.read_data2, 32'd0);
`endif
    step(rtype(5'd9, 5'd9, 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
    check("raw_next_rd1", bus.read_data1, 32'h12345678);

    // r0 and r27 ignore writes (and are never bypassed)
    step(rtype(5'd0, 5'd27, 5'd0), 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check("r0_wr_rd1", bus.read_data1, 32'd0);
    check("r0_wr_rd2", bus.read_data2, 32'h0000ABCD);
    step(rtype(5'd27, 5'd0, 5'd0), 32'd0, 1'b1, 5'd27, 32'hFFFFFFFF);
    check("r27_wr_rd1", bus.read_data1, 32'h0000ABCD);
    check("r27_wr_rd2", bus.read_data2, 32'd0);
    step(rtype(5'd0, 5'd27, 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
    check("r0_after", bus.read_data1, 32'd0);
    check("r27_after", bus.read_data2, 32'h0000ABCD);
    bus.register_input = 32'h13572468;
    step(rtype(5'd27, 5'd5, 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
    check("r27_follow", bus.read_data1, 32'h13572468);
    check("r5_kept", bus.read_data2, 32'hDEADBEEF);

    // Unknown opcode: bubble control, PC still passes through
    step({6'b111111, 5'd5, 5'd9, 16'h1234}, 32'h0040_0010, 1'b0, 5'd0, 32'd0);
    check("unk_ctrl", {20'd0, ctrl_obs()}, 32'd0);
    check("unk_pc", bus.new_pc_value, 32'h0040_0010);
    check("unk_rd1", bus.read_data1, 32'hDEADBEEF);
    check("unk_rd2", bus.read_data2, 32'h12345678);

    // Mid-stream reset overrides capture and a pending write
    rst_n = 1'b0;
    step(32'h8C28FFFC, 32'h0000_0300, 1'b1, 5'd6, 32'h0000_0055);
    check_all_zero("midrst");
    rst_n = 1'b1;
    step(rtype(5'd5, 5'd6, 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
    check("midrst_r5", bus.read_data1, 32'd0);
    check("midrst_r6", bus.read_data2, 32'd0);
    step(rtype(5'd9, 5'd27, 5'd0), 32'd0, 1'b0, 5'd0, 32'd0);
    check("midrst_r9", bus.read_data1, 32'd0);
    check("midrst_r27", bus.read_data2, 32'h13572468);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
